// File: rtl/control_lectura_rtc.sv
// control_lectura_rtc: one register read from a multiplexed-AD RTC.
// The address phase strobes WR_n with the latched address on the bus, a
// turnaround gap follows, then the data phase strobes RD_n and captures
// ad_in. Every output is a flop.
module control_lectura_rtc #(
  parameter int unsigned T_SU  = 2,
  parameter int unsigned T_PW  = 4,
  parameter int unsigned T_H   = 2,
  parameter int unsigned T_GAP = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Inicio_R,
  input  logic [7:0] Addr_R,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       CS_n,
  output logic       AD_n,
  output logic       WR_n,
  output logic       RD_n,
  output logic [7:0] Data_R,
  output logic       Final_RD,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE, A_SET, A_WR, A_HLD, GAP, D_SET, D_RD, D_HLD, DONE
  } state_t;

  localparam logic [3:0] SU_L  = 4'(T_SU - 1);
  localparam logic [3:0] PW_L  = 4'(T_PW - 1);
  localparam logic [3:0] H_L   = 4'(T_H - 1);
  localparam logic [3:0] GAP_L = 4'(T_GAP - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic [7:0] ad_out_q, ad_out_d;
  logic       ad_oe_q, ad_oe_d;
  logic       cs_n_q, cs_n_d;
  logic       ad_n_q, ad_n_d;
  logic       wr_n_q, wr_n_d;
  logic       rd_n_q, rd_n_d;
  logic       final_q, final_d;
  logic       busy_q, busy_d;

  // Next state, phase counter, address latch and read-data capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == '0) ? '0 : 4'(cnt_q - 4'd1);
    addr_d  = addr_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (Inicio_R) begin
          state_d = A_SET;
          cnt_d   = SU_L;
          addr_d  = Addr_R;
        end
      end
      A_SET: if (cnt_q == '0) begin state_d = A_WR;  cnt_d = PW_L;  end
      A_WR:  if (cnt_q == '0) begin state_d = A_HLD; cnt_d = H_L;   end
      A_HLD: if (cnt_q == '0) begin state_d = GAP;   cnt_d = GAP_L; end
      GAP:   if (cnt_q == '0) begin state_d = D_SET; cnt_d = SU_L;  end
      D_SET: if (cnt_q == '0) begin state_d = D_RD;  cnt_d = PW_L;  end
      D_RD: begin
        if (cnt_q == '0) begin
          state_d = D_HLD;
          cnt_d   = H_L;
          data_d  = ad_in;
        end
      end
      D_HLD: if (cnt_q == '0) begin state_d = DONE; cnt_d = '0; end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Bus outputs decoded from the next state so they register alongside it.
  always_comb begin
    ad_out_d = '0;
    ad_oe_d  = 1'b0;
    cs_n_d   = 1'b1;
    ad_n_d   = 1'b1;
    wr_n_d   = 1'b1;
    rd_n_d   = 1'b1;
    final_d  = 1'b0;
    busy_d   = (state_d != IDLE);
    unique case (state_d)
      A_SET, A_WR, A_HLD: begin
        cs_n_d   = 1'b0;
        ad_n_d   = 1'b0;
        ad_oe_d  = 1'b1;
        ad_out_d = addr_d;
        wr_n_d   = (state_d != A_WR);
      end
      D_SET, D_HLD: cs_n_d = 1'b0;
      D_RD: begin
        cs_n_d = 1'b0;
        rd_n_d = 1'b0;
      end
      DONE:    final_d = 1'b1;
      default: ;
    endcase
  end

  // State and output registers, asynchronously cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      ad_out_q <= '0;
      ad_oe_q  <= 1'b0;
      cs_n_q   <= 1'b1;
      ad_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      rd_n_q   <= 1'b1;
      final_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      ad_out_q <= ad_out_d;
      ad_oe_q  <= ad_oe_d;
      cs_n_q   <= cs_n_d;
      ad_n_q   <= ad_n_d;
      wr_n_q   <= wr_n_d;
      rd_n_q   <= rd_n_d;
      final_q  <= final_d;
      busy_q   <= busy_d;
    end
  end

  assign ad_out   = ad_out_q;
  assign ad_oe    = ad_oe_q;
  assign CS_n     = cs_n_q;
  assign AD_n     = ad_n_q;
  assign WR_n     = wr_n_q;
  assign RD_n     = rd_n_q;
  assign Data_R   = data_q;
  assign Final_RD = final_q;
  assign busy     = busy_q;

endmodule

// File: doc/control_lectura_rtc.md
CONTROL_LECTURA_RTC -- requirements
Module: control_lectura_rtc

Interface
REQ-001 Parameters, one per line: name, default, meaning; every count SHALL be >= 1.
- T_SU, 2, setup cycles before each strobe.
- T_PW, 4, strobe (WR_n/RD_n) low width in cycles.
- T_H, 2, hold cycles after each strobe.
- T_GAP, 3, bus turnaround cycles between address and data phase.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state changes on rising edge.
- reset, in, 1, asynchronous, active-low reset.
- Inicio_R, in, 1, start request for one RTC register read.
- Addr_R, in, 8, RTC register address to read.
- ad_in, in, 8, multiplexed RTC AD bus, read side.
- ad_out, out, 8, multiplexed RTC AD bus, drive side.
- ad_oe, out, 1, 1 = block drives the AD bus.
- CS_n, out, 1, RTC chip select, active low.
- AD_n, out, 1, 0 = address phase, 1 = data phase.
- WR_n, out, 1, RTC write strobe, active low.
- RD_n, out, 1, RTC read strobe, active low.
- Data_R, out, 8, last captured read data.
- Final_RD, out, 1, one-cycle read-complete pulse.
- busy, out, 1, 1 whenever state is not IDLE.

Function
REQ-003 All outputs SHALL come directly from registers; no combinational path from inputs to outputs.
REQ-004 States: IDLE, A_SET, A_WR, A_HLD, GAP, D_SET, D_RD, D_HLD, DONE; a 4-bit down-counter times each phase.
REQ-005 IDLE: CS_n=AD_n=WR_n=RD_n=1, ad_oe=0, busy=0; Inicio_R=1 at an edge latches Addr_R and enters A_SET.
REQ-006 Inicio_R SHALL be ignored in every state except IDLE; Addr_R changes after acceptance SHALL have no effect.
REQ-007 A_SET lasts T_SU cycles: CS_n=0, AD_n=0, ad_oe=1, ad_out=latched address.
REQ-008 A_WR lasts T_PW cycles: as A_SET plus WR_n=0.
REQ-009 A_HLD lasts T_H cycles: WR_n=1, CS_n=0, AD_n=0, ad_oe=1, ad_out unchanged.
REQ-010 GAP lasts T_GAP cycles: CS_n=1, AD_n=1, ad_oe=0, ad_out=0x00.
REQ-011 D_SET lasts T_SU cycles: CS_n=0, AD_n=1, ad_oe=0.
REQ-012 D_RD lasts T_PW cycles: RD_n=0; ad_in SHALL be captured into Data_R at the edge ending the last D_RD cycle only.
REQ-013 D_HLD lasts T_H cycles: RD_n=1, CS_n=0, AD_n=1.
REQ-014 DONE lasts 1 cycle: all strobes inactive, Final_RD=1, busy=1; then IDLE unconditionally.
REQ-015 Latency: Final_RD SHALL be high in cycle 2*(T_SU+T_PW+T_H)+T_GAP+1 after the accepting edge (20 with defaults).
REQ-016 WR_n and RD_n SHALL never be low simultaneously; ad_oe SHALL never be 1 while AD_n=1.
REQ-017 Inicio_R held high continuously SHALL restart from the IDLE cycle following DONE; minimum period 21 cycles with defaults.
REQ-018 Data_R SHALL hold its value between captures; ad_in outside the capture edge SHALL not affect it.

Reset
REQ-019 reset=0 SHALL immediately force IDLE, counter=0, CS_n=AD_n=WR_n=RD_n=1, ad_oe=0, ad_out=0x00, Data_R=0x00, Final_RD=0, busy=0, asynchronously to clk.
REQ-020 Reset during any phase SHALL abort the cycle without generating Final_RD; operation resumes on the first edge after reset=1.

Verification
REQ-021 Reset asserted mid-cycle -> all outputs reach reset values within the same cycle, before the next clk edge.
REQ-022 Inicio_R=1 one cycle, Addr_R=0x21, ad_in=0x59 during D_RD -> ad_out=0x21 with WR_n low 4 cycles, RD_n low 4 cycles, Data_R=0x59, Final_RD high in cycle 20 only.
REQ-023 Inicio_R pulsed again in cycle 5 with Addr_R=0x33 -> ignored, ad_out stays 0x21, single Final_RD.
REQ-024 reset=0 during D_RD -> no Final_RD, Data_R=0x00; next Inicio_R completes a normal 20-cycle read.
REQ-025 Inicio_R held high, ad_in=0xA5 then 0x3C -> back-to-back reads, Final_RD pulses 21 cycles apart, Data_R=0xA5 then 0x3C.
REQ-026 ad_in changed in D_HLD to 0xFF after capture of 0x12 -> Data_R remains 0x12; WR_n/RD_n overlap and ad_oe/AD_n conflict never observed.
